// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parameterised multi-read-port register file with a per-register "pending"
// scoreboard bit. The pending bits let an issue stage mark a register as
// awaiting a result and see that status on every read port.
//
// Parameters
//   WIDTH    data bits per register
//   DEPTH    number of registers (power of two, 2..256)
//   NRD      number of independent combinational read ports (1..4)
//   ZERO_REG 1 = register 0 reads as zero and can never become pending
//   BYPASS   1 = same-cycle write data is forwarded to matching read ports
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (clears data and pending bits)
//   we         write enable
//   waddr      write address
//   wdata      write data
//   raddr      read addresses, port k at [k*AW +: AW]
//   rdata      read data, port k at [k*WIDTH +: WIDTH]
//   pend_set   mark register pend_addr as pending at the next edge
//   pend_addr  register to mark pending
//   rpend      bit k = register addressed by read port k is pending
//   any_pend   OR of all pending bits
// -----------------------------------------------------------------------------
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_addr,
  output logic [NRD-1:0]       rpend,
  output logic                 any_pend
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic             wr_en;
  logic             set_en;

  // Writes and pending marks aimed at a hardwired-zero register are dropped
  // here so neither the storage nor the scoreboard ever sees them.
  assign wr_en  = we       && !((ZERO_REG != 0) && (waddr     == '0));
  assign set_en = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

  // One-hot decode of the pending updates. A write retires the pending bit of
  // its register; a new pend_set marks one. Both are applied together below
  // with set taking priority, so a new producer issued on the same edge as the
  // old producer's writeback leaves the register pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_mask[i] = set_en && (pend_addr == AW'(i));
      clr_mask[i] = wr_en  && (waddr     == AW'(i));
    end
  end

  // Register storage. Reset clears every entry so no read can return X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Scoreboard pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

  assign any_pend = |pend;

  // Read ports. The bypass is gated with rst_n so that a write presented while
  // reset is held cannot leak onto rdata; the zero-register check overrides
  // everything, including the bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          hit;

    assign ra      = raddr[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit     = (BYPASS != 0) && rst_n && we && (waddr == ra);

    assign rdata[k*WIDTH +: WIDTH] = is_zero ? '0    :
                                     hit     ? wdata :
                                               mem[ra];
    assign rpend[k] = !is_zero && !hit && pend[ra];
  end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Directed testbench for regfile_param. Two instances share all inputs: one
// with the default bypass enabled, one with BYPASS=0, so forwarding behaviour
// can be compared against the unforwarded register contents on the same
// vectors. Inputs change just after the falling edge and outputs are sampled
// 2 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic [63:0] rdata_b;
  logic [1:0]  rpend_b;
  logic        any_pend_b;
  logic [63:0] rdata_n;
  logic [1:0]  rpend_n;
  logic        any_pend_n;

  int errors;
  int checks;

  regfile_param u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata_b),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rpend     (rpend_b),
    .any_pend  (any_pend_b)
  );

  regfile_param #(.BYPASS(0)) u_nobyp (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata_n),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rpend     (rpend_n),
    .any_pend  (any_pend_n)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs after the falling edge, then settle.
  task automatic applyStimulus(input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ps,
                               input logic [4:0] pa, input logic [4:0] ra0,
                               input logic [4:0] ra1);
    @(negedge clk);
    we        = w;
    waddr     = wa;
    wdata     = wd;
    pend_set  = ps;
    pend_addr = pa;
    raddr     = {ra1, ra0};
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset held with a write presented: nothing may leak to the outputs.
    rst_n     = 1'b0;
    we        = 1'b1;
    waddr     = 5'd4;
    wdata     = 32'hCAFEF00D;
    pend_set  = 1'b1;
    pend_addr = 5'd4;
    raddr     = {5'd4, 5'd4};
    #3;
    checkOutput("rst_rdata0",  rdata_b[31:0],  32'h0);
    checkOutput("rst_rdata1",  rdata_b[63:32], 32'h0);
    checkOutput("rst_rpend",   {30'h0, rpend_b}, 32'h0);
    checkOutput("rst_anypend", {31'h0, any_pend_b}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_edge_rdata0", rdata_b[31:0], 32'h0);
    checkOutput("rst_edge_anypend", {31'h0, any_pend_b}, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    we       = 1'b0;
    pend_set = 1'b0;

    // Every address reads zero and not pending after reset.
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
      checkOutput($sformatf("post_rst_rd0_%0d", a), rdata_b[31:0],  32'h0);
      checkOutput($sformatf("post_rst_rd1_%0d", a), rdata_b[63:32], 32'h0);
      checkOutput($sformatf("post_rst_rp_%0d", a), {30'h0, rpend_b}, 32'h0);
    end
    checkOutput("post_rst_anypend", {31'h0, any_pend_b}, 32'h0);

    // Plain write then read on both ports.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("r5_port0",       rdata_b[31:0],  32'hDEADBEEF);
    checkOutput("r5_port1",       rdata_b[63:32], 32'hDEADBEEF);
    checkOutput("r5_nobyp_port0", rdata_n[31:0],  32'hDEADBEEF);

    // Same-cycle forwarding vs. old value.
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd5);
    checkOutput("byp_r7_port0",   rdata_b[31:0],  32'h12345678);
    checkOutput("nobyp_r7_port0", rdata_n[31:0],  32'h0);
    checkOutput("byp_r5_port1",   rdata_b[63:32], 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("nobyp_r7_after", rdata_n[31:0],  32'h12345678);
    checkOutput("byp_r7_after",   rdata_b[63:32], 32'h12345678);

    // Register zero ignores writes and pend_set, even with bypass.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_same_byp",   rdata_b[31:0], 32'h0);
    checkOutput("r0_same_nobyp", rdata_n[31:0], 32'h0);
    checkOutput("r0_same_rpend", {30'h0, rpend_b}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_next_byp",     rdata_b[31:0],  32'h0);
    checkOutput("r0_next_nobyp",   rdata_n[63:32], 32'h0);
    checkOutput("r0_anypend",      {31'h0, any_pend_b}, 32'h0);
    checkOutput("r0_anypend_nobyp", {31'h0, any_pend_n}, 32'h0);

    // Pending scoreboard on r9.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    checkOutput("r9_before_edge", {31'h0, any_pend_b}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("r9_rpend",   {30'h0, rpend_b}, 32'h2);
    checkOutput("r9_anypend", {31'h0, any_pend_b}, 32'h1);
    // Writeback and new producer on the same edge.
    applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd0, 5'd9);
    checkOutput("r9_wb_rpend_byp",   {30'h0, rpend_b}, 32'h0);
    checkOutput("r9_wb_rpend_nobyp", {30'h0, rpend_n}, 32'h2);
    checkOutput("r9_wb_rdata_byp",   rdata_b[63:32], 32'h00000099);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput("r9_newprod_rpend",   {30'h0, rpend_b}, 32'h3);
    checkOutput("r9_newprod_anypend", {31'h0, any_pend_b}, 32'h1);
    checkOutput("r9_newprod_rdata",   rdata_b[31:0], 32'h00000099);
    // Writeback alone clears it.
    applyStimulus(1'b1, 5'd9, 32'h0000AAAA, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("r9_clr_rpend_byp",   {30'h0, rpend_b}, 32'h0);
    checkOutput("r9_clr_rpend_nobyp", {30'h0, rpend_n}, 32'h2);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    checkOutput("r9_cleared_rpend",    {30'h0, rpend_b}, 32'h0);
    checkOutput("r9_cleared_anypend",  {31'h0, any_pend_b}, 32'h0);
    checkOutput("r9_cleared_anypend_n", {31'h0, any_pend_n}, 32'h0);
    checkOutput("r9_cleared_rdata",    rdata_b[31:0], 32'h0000AAAA);

    // Write and pend_set to different registers on the same edge.
    applyStimulus(1'b1, 5'd10, 32'h00001010, 1'b1, 5'd11, 5'd10, 5'd11);
    checkOutput("indep_byp_rd0", rdata_b[31:0], 32'h00001010);
    checkOutput("indep_rpend0",  {30'h0, rpend_b}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11);
    checkOutput("indep_rd0",     rdata_b[31:0], 32'h00001010);
    checkOutput("indep_rpend1",  {30'h0, rpend_b}, 32'h2);
    checkOutput("indep_anypend", {31'h0, any_pend_b}, 32'h1);
    applyStimulus(1'b1, 5'd11, 32'h00000B0B, 1'b0, 5'd0, 5'd11, 5'd10);
    checkOutput("r11_wb_rpend_byp", {30'h0, rpend_b}, 32'h0);
    checkOutput("r11_wb_rpend_nob", {30'h0, rpend_n}, 32'h1);
    checkOutput("r11_wb_rdata_byp", rdata_b[31:0], 32'h00000B0B);
    checkOutput("r11_wb_rdata_nob", rdata_n[31:0], 32'h0);

    // r3 loaded and pending, then reset asserted mid-cycle during a write.
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd6, 32'h00001111, 1'b0, 5'd0, 5'd3, 5'd3);
    checkOutput("r3_loaded",  rdata_b[31:0], 32'hA5A5A5A5);
    checkOutput("r3_pending", {30'h0, rpend_b}, 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rd0",     rdata_b[31:0],  32'h0);
    checkOutput("async_rst_rd1",     rdata_b[63:32], 32'h0);
    checkOutput("async_rst_rpend",   {30'h0, rpend_b}, 32'h0);
    checkOutput("async_rst_anypend", {31'h0, any_pend_b}, 32'h0);
    checkOutput("async_rst_nobyp",   rdata_n[31:0], 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_rd0", rdata_b[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd3);
    checkOutput("r6_discarded", rdata_b[31:0],  32'h0);
    checkOutput("r3_cleared",   rdata_b[63:32], 32'h0);
    checkOutput("rst_release_anypend", {31'h0, any_pend_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
